// File: rtl/uart_cmd_frame_decoder.sv
`default_nettype none
// =============================================================================
// Module   : uart_cmd_frame_decoder
// Brief    : Sync-prefixed UART command parser with atomic channel commit,
//            mode flag, inter-byte timeout and saturating error counter.
//            Optional macro FRAME_CHECKSUM_EN enables XOR trailer checking.
// Revision : 1.0 - initial release
// =============================================================================
module uart_cmd_frame_decoder #(
    parameter int                NUM_CH      = 2,
    parameter int                DATA_W      = 16,
    parameter logic [7:0]        SYNC0       = 8'h61,
    parameter logic [7:0]        SYNC1       = 8'h62,
    parameter logic [7:0]        CMD_CTRL    = 8'h63,
    parameter logic [7:0]        CMD_MODE    = 8'h6D,
    parameter logic [DATA_W-1:0] CH_RESET    = '0,
    parameter int                TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     ch_update,
    output logic                     ctrl_mode,
    output logic [7:0]               err_cnt,
    output logic                     busy
);

    localparam int                BPC       = DATA_W / 8;
    localparam int                NBYTES    = NUM_CH * BPC;
    localparam int                IDXW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0]   c_LAST    = IDXW'(NBYTES - 1);
    localparam int                TCW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TCW-1:0]    c_TMAX    = TCW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit                c_TO_EN   = (TIMEOUT_CYC > 0);

    typedef enum logic [2:0] {
        S_HUNT0   = 3'd0,
        S_HUNT1   = 3'd1,
        S_CMD     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_TRAILER = 3'd4,
        S_MODE    = 3'd5
    } state_t;

    state_t                     r_state;
    logic [NUM_CH*DATA_W-1:0]   r_shadow;
    logic [IDXW-1:0]            r_idx;
    logic [TCW-1:0]             r_tcnt;
    logic                       w_timeout;
    logic                       w_trailer_ok;
    logic [7:0]                 w_err_inc;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0]                 r_csum;
    assign w_trailer_ok = (rx_data == r_csum);
`else
    assign w_trailer_ok = 1'b1;
`endif

    // A byte on the timeout cycle takes priority, hence the !rx_valid term.
    assign w_timeout = c_TO_EN && (r_state != S_HUNT0) && !rx_valid && (r_tcnt == c_TMAX);
    assign w_err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign busy      = (r_state != S_HUNT0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_HUNT0;
            r_shadow  <= '0;
            r_idx     <= '0;
            r_tcnt    <= '0;
            ch_data   <= {NUM_CH{CH_RESET}};
            ch_update <= 1'b0;
            ctrl_mode <= 1'b1;
            err_cnt   <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
        end else begin
            ch_update <= 1'b0;
            if (rx_valid) begin
                r_tcnt <= '0;
                case (r_state)
                    S_HUNT0: begin
                        if (rx_data == SYNC0)
                            r_state <= S_HUNT1;
                    end
                    S_HUNT1: begin
                        if (rx_data == SYNC1)
                            r_state <= S_CMD;
                        else if (rx_data != SYNC0)
                            r_state <= S_HUNT0;
                    end
                    S_CMD: begin
                        if (rx_data == CMD_CTRL) begin
                            r_state <= S_PAYLOAD;
                            r_idx   <= '0;
`ifdef FRAME_CHECKSUM_EN
                            r_csum  <= 8'd0;
`endif
                        end else if (rx_data == CMD_MODE) begin
                            r_state <= S_MODE;
                        end else begin
                            r_state <= S_HUNT0;
                            err_cnt <= w_err_inc;
                        end
                    end
                    S_PAYLOAD: begin
                        // Byte k lands in channel k/BPC, first byte of a channel is its MSB.
                        for (int j = 0; j < NBYTES; j++) begin
                            if (r_idx == IDXW'(j))
                                r_shadow[(j / BPC) * DATA_W + (BPC - 1 - (j % BPC)) * 8 +: 8] <= rx_data;
                        end
`ifdef FRAME_CHECKSUM_EN
                        r_csum <= r_csum ^ rx_data;
`endif
                        if (r_idx == c_LAST)
                            r_state <= S_TRAILER;
                        else
                            r_idx <= r_idx + IDXW'(1);
                    end
                    S_TRAILER: begin
                        if (w_trailer_ok) begin
                            ch_data   <= r_shadow;
                            ch_update <= 1'b1;
                        end else begin
                            err_cnt   <= w_err_inc;
                        end
                        r_state <= S_HUNT0;
                    end
                    S_MODE: begin
                        ctrl_mode <= rx_data[0];
                        r_state   <= S_HUNT0;
                    end
                    default: r_state <= S_HUNT0;
                endcase
            end else if (w_timeout) begin
                r_state  <= S_HUNT0;
                r_shadow <= '0;
                r_tcnt   <= '0;
                err_cnt  <= w_err_inc;
            end else if (r_state == S_HUNT0) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TCW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_frame_decoder.md
Name: uart_cmd_frame_decoder

Overview:
Byte-stream command parser between the UART receiver and the actuator control logic (motor PWM, servo PWM). Runs fully synchronous to the system clock, with a one-cycle byte strobe, rather than clocking on the receiver's ready pulse. Decodes sync-prefixed frames into NUM_CH channel values, which are committed atomically, plus a control-mode flag. Adds an inter-byte timeout, re-sync and an error counter.

Parameters:
NUM_CH, 2, number of channel values per control frame (1..8)
DATA_W, 16, bits per channel; must be a multiple of 8; sent big-endian, DATA_W/8 bytes per channel
SYNC0, 8'h61 ("a"), first sync byte
SYNC1, 8'h62 ("b"), second sync byte
CMD_CTRL, 8'h63 ("c"), control-frame command byte
CMD_MODE, 8'h6D ("m"), mode-frame command byte
CH_RESET, 0, reset value of every channel (DATA_W bits)
TIMEOUT_CYC, 50000, maximum clk cycles between bytes inside a frame; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
ch_data  out  NUM_CH*DATA_W  committed channel values; channel 0 is in the LSBs
ch_update  out  1  one-cycle pulse when ch_data is committed
ctrl_mode  out  1  control mode flag (1 = remote control)
err_cnt  out  8  saturating count of frame errors
busy  out  1  high while the state is not HUNT0

Behaviour:
- Reset, sampled at the clk edge while rst=1:
  - ch_data = all channels CH_RESET; ch_update = 0; ctrl_mode = 1; err_cnt = 0.
  - State = HUNT0; shadow registers and counters cleared.
  - Reset mid-frame discards the partial frame; no update is committed.
- Bytes are consumed only on cycles with rx_valid = 1. All transitions below occur on such a cycle unless stated otherwise.
- States:
  - HUNT0: SYNC0 -> HUNT1; any other byte -> stay.
  - HUNT1: SYNC1 -> CMD; SYNC0 -> stay in HUNT1 (re-sync); other -> HUNT0. No error is counted in HUNT0/HUNT1.
  - CMD: CMD_CTRL -> PAYLOAD with byte counter = 0 and checksum accumulator = 0; CMD_MODE -> MODE; other -> HUNT0, err_cnt+1.
  - PAYLOAD: write the byte into the shadow register.
    - Byte index k maps to channel k/(DATA_W/8); the first byte of each channel is its MSB.
    - Accumulator ^= byte.
    - After byte index NUM_CH*DATA_W/8-1 -> TRAILER.
  - TRAILER: the trailer byte is consumed (check rules under Optional Feature). On accept, all shadow registers are copied to ch_data and ch_update = 1, both in the cycle after the trailer strobe. -> HUNT0.
  - MODE: ctrl_mode <= rx_data[0] in the cycle after the strobe. -> HUNT0.
- ch_update is high for exactly one cycle per accepted frame. ch_data is otherwise unchanged; it is never partially updated.
- Timeout:
  - The cycle counter is cleared on every accepted byte and held at 0 in HUNT0.
  - In any other state, when the counter reaches TIMEOUT_CYC-1 on a cycle with rx_valid=0 -> HUNT0, err_cnt+1, shadow data discarded.
  - If rx_valid and the timeout condition coincide, the byte wins: it is processed and the counter is cleared.
- err_cnt saturates at 255; it does not wrap.
- Back-to-back strobes on consecutive cycles must be handled with no byte loss.

Optional Feature:
FRAME_CHECKSUM_EN
- Defined:
  - Trailer byte must equal the XOR of all payload bytes.
  - Match -> commit.
  - Mismatch -> no commit, no ch_update, err_cnt+1, -> HUNT0.
- Undefined: the trailer byte is consumed and ignored; the frame is always committed.

Test Plan:
1. Reset release, no input -> ch_data = 0, ctrl_mode = 1, err_cnt = 0, ch_update = 0, busy = 0.
2. Control frame, defaults. Bytes 61 62 63 05 DC 02 00, then trailer 0xDB (XOR of payload) -> one ch_update pulse one cycle after the trailer. Channel 0 = 0x05DC, channel 1 = 0x0200. Same result with FRAME_CHECKSUM_EN off and trailer 0x00.
3. FRAME_CHECKSUM_EN on, same frame with trailer 0x00 -> no ch_update, ch_data unchanged, err_cnt = 1. A following valid frame commits normally.
4. Mode frame 61 62 6D 00 -> ctrl_mode = 0 one cycle after the last strobe. Then 61 61 62 6D 01 -> ctrl_mode = 1 (re-sync path). 61 62 7A -> err_cnt+1.
5. TIMEOUT_CYC = 100, send 61 62 63 05 then idle 100 cycles -> busy drops, err_cnt+1. A full frame afterwards commits. A byte arriving exactly on the timeout cycle is processed, not dropped.
6. Force 300 bad command bytes, each after 61 62 -> err_cnt = 255 (saturated). Assert rst mid-payload -> all outputs return to reset values with no ch_update.
